// File: rtl/io_pad_bank_if.sv
// GPIO pad bank signal bundle: core-side controls, pad levels, filtered inputs and interrupts.
// No latency of its own; the bank registers every output.
// No backpressure: all signals are level or single-cycle strobes.
interface io_pad_bank_if #(
    parameter int NUM_PINS = 16,
    parameter int DBNC_W   = 16
);
    logic [NUM_PINS-1:0] gpio_o;
    logic [NUM_PINS-1:0] gpio_oen;
    logic [NUM_PINS-1:0] od_mode_i;
    logic [NUM_PINS-1:0] dbnc_en_i;
    logic [DBNC_W-1:0]   dbnc_limit_i;
    logic [NUM_PINS-1:0] irq_rise_en_i;
    logic [NUM_PINS-1:0] irq_fall_en_i;
    logic [NUM_PINS-1:0] irq_clr_i;
    logic [NUM_PINS-1:0] pad_i;
    logic [NUM_PINS-1:0] pad_o;
    logic [NUM_PINS-1:0] pad_oe_o;
    logic [NUM_PINS-1:0] gpio_i;
    logic [NUM_PINS-1:0] irq_pend_o;
    logic                irq_o;

    modport master (
        output gpio_o, gpio_oen, od_mode_i, dbnc_en_i, dbnc_limit_i,
               irq_rise_en_i, irq_fall_en_i, irq_clr_i, pad_i,
        input  pad_o, pad_oe_o, gpio_i, irq_pend_o, irq_o
    );

    modport slave (
        input  gpio_o, gpio_oen, od_mode_i, dbnc_en_i, dbnc_limit_i,
               irq_rise_en_i, irq_fall_en_i, irq_clr_i, pad_i,
        output pad_o, pad_oe_o, gpio_i, irq_pend_o, irq_o
    );
endinterface

// File: rtl/io_pad_bank.sv
// GPIO pad bank: push-pull/open-drain output drive, synchronised + debounced inputs, edge interrupts.
// Latency: output path 1 cycle; input SYNC_STAGES+L+1 cycles (SYNC_STAGES+1 with debounce bypassed).
// No backpressure: free-running per-pin pipelines, pending bits are sticky until cleared.
module io_pad_bank #(
    parameter int NUM_PINS    = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DBNC_W      = 16
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    io_pad_bank_if.slave  bus
);

    localparam logic [DBNC_W-1:0] CNT_ONE = DBNC_W'(1);

    logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_PINS-1:0] s;

    logic [NUM_PINS-1:0] st_q, st_d;
    logic [DBNC_W-1:0]   cnt_q [NUM_PINS];
    logic [DBNC_W-1:0]   cnt_d [NUM_PINS];
    logic [NUM_PINS-1:0] upd;
    logic [NUM_PINS-1:0] rise, fall;

    logic [NUM_PINS-1:0] pend_q, pend_d;
    logic [NUM_PINS-1:0] pad_q, pad_d;
    logic [NUM_PINS-1:0] oe_q, oe_d;

    // Output drive: open-drain never drives high, it only pulls low or releases.
    always_comb begin
        pad_d = bus.gpio_o & ~bus.od_mode_i;
        oe_d  = bus.gpio_oen & ~(bus.od_mode_i & bus.gpio_o);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pad_q <= '0;
            oe_q  <= '0;
        end else begin
            pad_q <= pad_d;
            oe_q  <= oe_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= bus.pad_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // A disabled debounce acts as limit 0; >= keeps a lowered limit from stalling a running count.
    always_comb begin
        st_d = st_q;
        upd  = '0;
        for (int i = 0; i < NUM_PINS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s[i] == st_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= (bus.dbnc_en_i[i] ? bus.dbnc_limit_i : '0)) begin
                st_d[i]  = s[i];
                cnt_d[i] = '0;
                upd[i]   = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            st_q <= '0;
            for (int i = 0; i < NUM_PINS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            st_q <= st_d;
            for (int i = 0; i < NUM_PINS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Set takes priority over clear so an edge coinciding with a clear is not lost.
    always_comb begin
        rise   = upd & st_d;
        fall   = upd & ~st_d;
        pend_d = (pend_q & ~bus.irq_clr_i)
               | (rise & bus.irq_rise_en_i)
               | (fall & bus.irq_fall_en_i);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign bus.pad_o      = pad_q;
    assign bus.pad_oe_o   = oe_q;
    assign bus.gpio_i     = st_q;
    assign bus.irq_pend_o = pend_q;
    assign bus.irq_o      = |pend_q;

endmodule

// File: tb/tb_io_pad_bank.sv
// Bench for io_pad_bank: output-mode table and random scoreboard, debounce/bypass timing,
// interrupt set/clear priority and asynchronous reset in the middle of a debounce count.
module tb_io_pad_bank;

    localparam int NP = 16;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    io_pad_bank_if #(.NUM_PINS(NP), .DBNC_W(DW)) bus ();

    io_pad_bank #(.NUM_PINS(NP), .SYNC_STAGES(2), .DBNC_W(DW)) dut (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .bus      (bus)
    );

    typedef struct {
        logic [NP-1:0] pad;
        logic [NP-1:0] oe;
    } out_exp_t;

    typedef struct {
        logic oen;
        logic o;
        logic od;
        logic exp_pad;
        logic exp_oe;
    } pin3_vec_t;

    out_exp_t sb_q[$];
    pin3_vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic out_exp_t model_out(input logic [NP-1:0] o, input logic [NP-1:0] oen,
                                           input logic [NP-1:0] od);
        out_exp_t r;
        for (int i = 0; i < NP; i++) begin
            if (od[i]) begin
                r.pad[i] = 1'b0;
                r.oe[i]  = oen[i] && !o[i];
            end else begin
                r.pad[i] = o[i];
                r.oe[i]  = oen[i];
            end
        end
        return r;
    endfunction

    task automatic drive_out(input logic [NP-1:0] o, input logic [NP-1:0] oen,
                             input logic [NP-1:0] od, input out_exp_t exp);
        bus.gpio_o    = o;
        bus.gpio_oen  = oen;
        bus.od_mode_i = od;
        sb_q.push_back(exp);
    endtask

    task automatic check_out(input string name);
        out_exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got %0h, expected an entry", name, bus.pad_o);
        end else begin
            e = sb_q.pop_front();
            check({name, ".pad_o"}, 32'(bus.pad_o), 32'(e.pad));
            check({name, ".pad_oe_o"}, 32'(bus.pad_oe_o), 32'(e.oe));
        end
    endtask

    task automatic set_defaults();
        bus.gpio_o        = '0;
        bus.gpio_oen      = '0;
        bus.od_mode_i     = '0;
        bus.dbnc_en_i     = '1;
        bus.dbnc_limit_i  = 16'd4;
        bus.irq_rise_en_i = '0;
        bus.irq_fall_en_i = '0;
        bus.irq_clr_i     = '0;
        bus.pad_i         = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_defaults();
        #12;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        out_exp_t ex;
        logic [NP-1:0] ro, roen, rod;

        tbl[0] = '{oen: 1, o: 1, od: 0, exp_pad: 1, exp_oe: 1};
        tbl[1] = '{oen: 1, o: 1, od: 1, exp_pad: 0, exp_oe: 0};
        tbl[2] = '{oen: 1, o: 0, od: 1, exp_pad: 0, exp_oe: 1};
        tbl[3] = '{oen: 0, o: 0, od: 1, exp_pad: 0, exp_oe: 0};
        tbl[4] = '{oen: 0, o: 1, od: 0, exp_pad: 1, exp_oe: 0};
        tbl[5] = '{oen: 1, o: 0, od: 0, exp_pad: 0, exp_oe: 1};

        // Reset with every input high
        rst_n = 1'b0;
        bus.gpio_o = '1; bus.gpio_oen = '1; bus.od_mode_i = '1; bus.dbnc_en_i = '1;
        bus.dbnc_limit_i = '1; bus.irq_rise_en_i = '1; bus.irq_fall_en_i = '1;
        bus.irq_clr_i = '0; bus.pad_i = '1;
        #22;
        check("rst.pad_o", 32'(bus.pad_o), 32'h0);
        check("rst.pad_oe_o", 32'(bus.pad_oe_o), 32'h0);
        check("rst.gpio_i", 32'(bus.gpio_i), 32'h0);
        check("rst.irq_pend_o", 32'(bus.irq_pend_o), 32'h0);
        check("rst.irq_o", 32'(bus.irq_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.push_back('{pad: '0, oe: '0});
        tick();
        check_out("rst_release_od");
        drive_out('1, '1, '0, '{pad: '1, oe: '1});
        tick();
        check_out("rst_release_pp");

        do_reset();
        tick();

        // Pin 3 output-mode table
        foreach (tbl[r]) begin
            ex.pad = '0;
            ex.oe  = '0;
            ex.pad[3] = tbl[r].exp_pad;
            ex.oe[3]  = tbl[r].exp_oe;
            drive_out(NP'(tbl[r].o) << 3, NP'(tbl[r].oen) << 3, NP'(tbl[r].od) << 3, ex);
            tick();
            check_out($sformatf("pin3_row%0d", r));
        end

        // Random output patterns against the model
        for (int n = 0; n < 12; n++) begin
            ro   = NP'($urandom);
            roen = NP'($urandom);
            rod  = NP'($urandom);
            drive_out(ro, roen, rod, model_out(ro, roen, rod));
            tick();
            check_out($sformatf("rand%0d", n));
        end

        // Debounce pin 0, L=4: step appears exactly 7 clocks later
        bus.pad_i[0] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("dbnc_rise_k%0d", k), 32'(bus.gpio_i[0]), 32'(k >= 7));
        end
        bus.pad_i[0] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
        end
        check("dbnc_fall", 32'(bus.gpio_i[0]), 32'h0);

        // A 4-cycle pulse is rejected
        bus.pad_i[0] = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        bus.pad_i[0] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("pulse4_k%0d", k), 32'(bus.gpio_i[0]), 32'h0);
        end

        // A 5-cycle pulse just passes
        bus.pad_i[0] = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        bus.pad_i[0] = 1'b0;
        tick();
        check("pulse5_before", 32'(bus.gpio_i[0]), 32'h0);
        tick();
        check("pulse5_pass", 32'(bus.gpio_i[0]), 32'h1);
        for (int k = 0; k < 10; k++) tick();
        check("pulse5_settle", 32'(bus.gpio_i[0]), 32'h0);
        check("no_irq_when_disabled", 32'(bus.irq_pend_o), 32'h0);

        // Bypass on pin 5
        bus.dbnc_en_i[5] = 1'b0;
        bus.pad_i[5] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("bypass_k%0d", k), 32'(bus.gpio_i[5]), 32'(k >= 3));
        end

        // IRQ on pin 7: rise only
        bus.dbnc_en_i[7] = 1'b0;
        bus.irq_rise_en_i[7] = 1'b1;
        bus.pad_i[7] = 1'b1;
        tick(); tick();
        check("irq_rise_early", 32'(bus.irq_pend_o[7]), 32'h0);
        tick();
        check("irq_rise_pend", 32'(bus.irq_pend_o), 32'h0080);
        check("irq_rise_o", 32'(bus.irq_o), 32'h1);
        bus.pad_i[7] = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("irq_fall_ignored", 32'(bus.irq_pend_o), 32'h0080);
        bus.irq_clr_i[7] = 1'b1;
        tick();
        bus.irq_clr_i[7] = 1'b0;
        check("irq_clr_alone", 32'(bus.irq_pend_o), 32'h0);
        check("irq_clr_o", 32'(bus.irq_o), 32'h0);

        // Pending set by a rise, then a second rise lands together with a clear
        bus.pad_i[7] = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        check("irq_rise2", 32'(bus.irq_pend_o[7]), 32'h1);
        bus.pad_i[7] = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        bus.pad_i[7] = 1'b1;
        tick(); tick();
        bus.irq_clr_i[7] = 1'b1;
        tick();
        bus.irq_clr_i[7] = 1'b0;
        check("irq_set_wins", 32'(bus.irq_pend_o[7]), 32'h1);
        bus.irq_rise_en_i[7] = 1'b0;
        tick();
        check("irq_en_off_keeps", 32'(bus.irq_pend_o[7]), 32'h1);
        bus.irq_clr_i[7] = 1'b1;
        tick();
        bus.irq_clr_i[7] = 1'b0;
        check("irq_clr_final", 32'(bus.irq_pend_o[7]), 32'h0);

        // Fall interrupt on pin 7
        bus.irq_fall_en_i[7] = 1'b1;
        bus.pad_i[7] = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check("irq_fall_pend", 32'(bus.irq_pend_o), 32'h0080);

        // Asynchronous reset in the middle of a long debounce
        do_reset();
        tick();
        bus.gpio_o = '1; bus.gpio_oen = '1;
        bus.dbnc_limit_i = 16'd100;
        bus.pad_i[0] = 1'b1;
        for (int k = 0; k < 52; k++) tick();
        check("mid_pad_o", 32'(bus.pad_o), 32'hffff);
        check("mid_gpio_i", 32'(bus.gpio_i[0]), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pad_o", 32'(bus.pad_o), 32'h0);
        check("arst_pad_oe_o", 32'(bus.pad_oe_o), 32'h0);
        check("arst_gpio_i", 32'(bus.gpio_i), 32'h0);
        check("arst_irq_o", 32'(bus.irq_o), 32'h0);
        bus.gpio_oen = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 103; k++) begin
            tick();
            if (k >= 100) begin
                check($sformatf("rearm_k%0d", k), 32'(bus.gpio_i[0]), 32'(k >= 103));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
